// File: rtl/uart_mem_monitor.sv
// uart_mem_monitor: decodes UART command frames into word reads/writes on dpram port 2 and replies over UART
module uart_mem_monitor #(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 5_000_000,
  parameter logic [7:0] OP_WRITE = 8'h57,
  parameter logic [7:0] OP_READ = 8'h52,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  input  logic [15:0]       mem_dout,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_DH, GET_DL, MEM_WR, MEM_RD, MEM_WAIT, TX_LOAD, TX_BUSY
  } state_t;
  state_t state, nxt;
  logic rx_q, ev, op_ok, get_st, tmo_hit, overrun, is_wr;
  logic [7:0] ah, dh, q0, q1;
  logic [1:0] qn;
  logic [CW-1:0] tmo;
  assign ev = rx_ready & ~rx_q;
  assign op_ok = rx_data == OP_WRITE || rx_data == OP_READ;
  assign get_st = state inside {GET_AH, GET_AL, GET_DH, GET_DL};
  assign tmo_hit = get_st && !ev && tmo == CW'(TIMEOUT - 1);
  assign overrun = ev && !get_st && state != IDLE;
  assign busy = state != IDLE;
  assign mem_we = state == MEM_WR;
  // State register
  always_ff @(posedge clock or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  // Next-state: frame bytes advance on byte events, an expired gap abandons the frame
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (ev) nxt = op_ok ? GET_AH : TX_LOAD;
      GET_AH:   if (ev) nxt = GET_AL;
      GET_AL:   if (ev) nxt = is_wr ? GET_DH : MEM_RD;
      GET_DH:   if (ev) nxt = GET_DL;
      GET_DL:   if (ev) nxt = MEM_WR;
      MEM_WR:   nxt = TX_LOAD;
      MEM_RD:   nxt = MEM_WAIT;
      MEM_WAIT: nxt = TX_LOAD;
      TX_LOAD:  if (tx_start && !tx_ready) nxt = TX_BUSY;
      TX_BUSY:  if (tx_ready) nxt = qn != 2'd0 ? TX_LOAD : IDLE;
      default:  nxt = IDLE;
    endcase
    if (tmo_hit) nxt = IDLE;
  end
  // Datapath: edge detect, gap timer, frame capture, reply queue and tx handshake
  always_ff @(posedge clock or negedge n_rst)
    if (!n_rst) begin
      rx_q <= 1'b1;
      err <= 1'b0;
      tmo <= '0;
      is_wr <= 1'b0;
      ah <= '0;
      dh <= '0;
      q0 <= '0;
      q1 <= '0;
      qn <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
    end else begin
      rx_q <= rx_ready;
      err <= (state == IDLE && ev && !op_ok) || tmo_hit || overrun;
      tmo <= (get_st && !ev) ? tmo + 1'b1 : '0;
      if (state == IDLE && ev) begin
        is_wr <= rx_data == OP_WRITE;
        q0 <= NAK_BYTE;
        qn <= 2'd1;
      end
      if (state == GET_AH && ev) ah <= rx_data;
      if (state == GET_AL && ev) mem_addr <= ADDR_W'({ah, rx_data});
      if (state == GET_DH && ev) dh <= rx_data;
      if (state == GET_DL && ev) mem_din <= {dh, rx_data};
      if (state == MEM_WR) begin
        q0 <= ACK_BYTE;
        qn <= 2'd1;
      end
      if (state == MEM_WAIT) begin
        q0 <= mem_dout[15:8];
        q1 <= mem_dout[7:0];
        qn <= 2'd2;
      end
      if (state == TX_LOAD) begin
        if (tx_start && !tx_ready) begin
          tx_start <= 1'b0;
          q0 <= q1;
          qn <= qn - 2'd1;
        end else begin
          tx_start <= 1'b1;
          tx_data <= q0;
        end
      end
    end
endmodule
